// File: rtl/remap_cache_fill_ctrl_pkg.sv
// Shared configuration for the remap cache fill path.
package TauCfg;
  localparam int LOCAL_ADDR_BW0 = 5;
  localparam int DATA_BW        = 8;
  localparam int VSIZE          = 2;
  localparam int N_ICFG         = 4;
endpackage

// File: rtl/remap_cache_fill_ctrl_fifo.sv
// Occupancy FIFO: one {id,len} entry per live allocation, in ring order.
module RemapAllocFifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 8
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] i_data,
  output logic             full,
  output logic             empty,
  output logic [WIDTH-1:0] head
);
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    rd_ptr, wr_ptr;
  logic [CW-1:0]    count;
  logic             do_push, do_pop;

  function automatic logic [PW-1:0] nxt(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign head    = mem[rd_ptr];

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= nxt(wr_ptr);
      if (do_pop)  rd_ptr <= nxt(rd_ptr);
      count <= count + CW'(do_push) - CW'(do_pop);
    end
  end

  always_ff @(posedge i_clk)
    if (do_push) mem[wr_ptr] <= i_data;
endmodule

// File: rtl/remap_cache_fill_ctrl.sv
// Ring-buffer fill controller: allocates cache lines by credit, streams fill
// data into the SRAM ring, and returns credit when allocations are retired.
module remap_cache_fill_ctrl import TauCfg::*; #(
  parameter  int LBW     = LOCAL_ADDR_BW0,
  localparam int HBW     = LBW - $clog2(VSIZE),
  localparam int NDATA   = 1 << HBW,
  localparam int ICFG_BW = $clog2(N_ICFG + 1),
  localparam int LEN_BW  = HBW + 1
) (
  input  logic                           i_clk,
  input  logic                           i_rst,
  input  logic                           alloc_rdy,
  output logic                           alloc_ack,
  input  logic [ICFG_BW-1:0]             i_alloc_id,
  input  logic [LEN_BW-1:0]              i_alloc_len,
  input  logic                           din_rdy,
  output logic                           din_ack,
  input  logic [VSIZE-1:0][DATA_BW-1:0]  i_din,
  output logic                           wad_dval,
  output logic [HBW-1:0]                 o_whiaddr,
  output logic [VSIZE-1:0][DATA_BW-1:0]  o_wdata,
  output logic                           filled_dval,
  output logic [ICFG_BW-1:0]             o_filled_id,
  input  logic                           free_dval,
  input  logic [ICFG_BW-1:0]             i_free_id,
  output logic                           o_free_err,
  output logic [LEN_BW-1:0]              o_credit
);
  typedef enum logic [1:0] {IDLE, FILL, DONE} state_t;

  state_t                    state;
  logic [HBW-1:0]            wptr;
  logic [LEN_BW-1:0]         credit, remaining;
  logic [ICFG_BW-1:0]        id_q;
  logic                      fifo_full, fifo_empty, pop;
  logic [ICFG_BW+LEN_BW-1:0] fifo_head;
  logic [ICFG_BW-1:0]        head_id;
  logic [LEN_BW-1:0]         head_len;
  logic                      bad_len, alloc_go, free_bad, ovf;
  logic [LEN_BW:0]           credit_sum;

  assign head_id  = fifo_head[ICFG_BW+LEN_BW-1:LEN_BW];
  assign head_len = fifo_head[LEN_BW-1:0];
  assign bad_len  = (i_alloc_len == '0) || (i_alloc_len > LEN_BW'(NDATA));

  // Bad lengths are consumed so the requester never deadlocks on them.
  assign alloc_ack = (state == IDLE) && alloc_rdy &&
                     (bad_len || (credit >= i_alloc_len && !fifo_full));
  assign alloc_go  = alloc_ack && !bad_len;
  assign din_ack   = (state == FILL) && din_rdy;
  assign pop       = free_dval && !fifo_empty;
  assign free_bad  = free_dval && (fifo_empty || head_id != i_free_id);

  // Credit uses the registered value for the alloc check; the retire adds back here.
  assign credit_sum = {1'b0, credit}
                    + (pop      ? {1'b0, head_len}    : '0)
                    - (alloc_go ? {1'b0, i_alloc_len} : '0);
  assign ovf        = credit_sum > (LEN_BW + 1)'(NDATA);
  assign o_credit   = credit;

  RemapAllocFifo #(.DEPTH(N_ICFG), .WIDTH(ICFG_BW + LEN_BW)) u_fifo (
    .i_clk  (i_clk),
    .i_rst  (i_rst),
    .push   (alloc_go),
    .pop    (pop),
    .i_data ({i_alloc_id, i_alloc_len}),
    .full   (fifo_full),
    .empty  (fifo_empty),
    .head   (fifo_head)
  );

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state       <= IDLE;
      wptr        <= '0;
      credit      <= LEN_BW'(NDATA);
      remaining   <= '0;
      id_q        <= '0;
      wad_dval    <= 1'b0;
      filled_dval <= 1'b0;
      o_free_err  <= 1'b0;
      o_whiaddr   <= '0;
      o_filled_id <= '0;
    end else begin
      wad_dval    <= din_ack;
      filled_dval <= 1'b0;
      credit      <= ovf ? LEN_BW'(NDATA) : credit_sum[LEN_BW-1:0];
      if ((alloc_ack && bad_len) || free_bad || ovf) o_free_err <= 1'b1;
      if (din_ack) begin
        o_whiaddr <= wptr;
        wptr      <= wptr + HBW'(1);
        remaining <= remaining - LEN_BW'(1);
      end
      case (state)
        IDLE: if (alloc_go) begin
          id_q      <= i_alloc_id;
          remaining <= i_alloc_len;
          state     <= FILL;
        end
        FILL: if (din_ack && remaining == LEN_BW'(1)) begin
          filled_dval <= 1'b1;
          o_filled_id <= id_q;
          state       <= DONE;
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  always_ff @(posedge i_clk)
    if (din_ack) o_wdata <= i_din;
endmodule

// File: tb/tb_remap_cache_fill_ctrl.sv
// Directed + randomized checks of the fill controller against a queue/credit model.
module tb_remap_cache_fill_ctrl;
  import TauCfg::*;
  localparam int HBW     = LOCAL_ADDR_BW0 - $clog2(VSIZE);
  localparam int NDATA   = 1 << HBW;
  localparam int ICFG_BW = $clog2(N_ICFG + 1);
  localparam int LEN_BW  = HBW + 1;
  localparam int WD      = VSIZE * DATA_BW;

  logic i_clk = 0, i_rst = 1;
  logic alloc_rdy = 0, alloc_ack, din_rdy = 0, din_ack;
  logic [ICFG_BW-1:0] i_alloc_id = '0, i_free_id = '0, o_filled_id;
  logic [LEN_BW-1:0]  i_alloc_len = '0, o_credit;
  logic [VSIZE-1:0][DATA_BW-1:0] i_din = '0, o_wdata;
  logic wad_dval, filled_dval, free_dval = 0, o_free_err;
  logic [HBW-1:0] o_whiaddr;

  remap_cache_fill_ctrl dut (
    .i_clk(i_clk), .i_rst(i_rst), .alloc_rdy(alloc_rdy), .alloc_ack(alloc_ack),
    .i_alloc_id(i_alloc_id), .i_alloc_len(i_alloc_len), .din_rdy(din_rdy),
    .din_ack(din_ack), .i_din(i_din), .wad_dval(wad_dval), .o_whiaddr(o_whiaddr),
    .o_wdata(o_wdata), .filled_dval(filled_dval), .o_filled_id(o_filled_id),
    .free_dval(free_dval), .i_free_id(i_free_id), .o_free_err(o_free_err),
    .o_credit(o_credit)
  );

  always #5 i_clk = ~i_clk;

  int n_cmp = 0, n_bad = 0;
  int m_credit, m_wptr, m_err;
  int qid[$], qlen[$];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge i_clk); #1;
  endtask

  task automatic do_reset();
    i_rst = 1; tick(); tick(); i_rst = 0;
    m_credit = NDATA; m_wptr = 0; m_err = 0;
    qid.delete(); qlen.delete();
  endtask

  task automatic alloc(input int id, input int len);
    int w = 0;
    alloc_rdy = 1; i_alloc_id = ICFG_BW'(id); i_alloc_len = LEN_BW'(len);
    #1;
    while (alloc_ack !== 1'b1 && w < 50) begin tick(); w++; end
    chk("alloc_ack", alloc_ack, 1);
    tick(); alloc_rdy = 0;
    qid.push_back(id); qlen.push_back(len); m_credit -= len;
    chk("credit_after_alloc", o_credit, m_credit);
  endtask

  task automatic fill(input int id, input int n);
    logic [WD-1:0] d;
    din_rdy = 1;
    for (int k = 0; k < n; k++) begin
      d = WD'($urandom); i_din = d;
      tick();
      chk("wad_dval", wad_dval, 1);
      chk("whiaddr", o_whiaddr, m_wptr);
      chk("wdata", o_wdata, d);
      chk("filled_dval", filled_dval, (k == n - 1));
      if (k == n - 1) chk("filled_id", o_filled_id, id);
      m_wptr = (m_wptr + 1) % NDATA;
    end
    din_rdy = 0; tick();
    chk("wad_idle", wad_dval, 0);
    chk("filled_idle", filled_dval, 0);
  endtask

  task automatic free_line(input int id);
    free_dval = 1; i_free_id = ICFG_BW'(id); tick(); free_dval = 0;
    if (qid.size() == 0) m_err = 1;
    else begin
      if (qid[0] != id) m_err = 1;
      m_credit += qlen[0];
      void'(qid.pop_front()); void'(qlen.pop_front());
    end
    chk("credit_after_free", o_credit, m_credit);
    chk("free_err", o_free_err, m_err);
  endtask

  initial begin
    int id, len;
    do_reset();
    chk("rst_credit", o_credit, NDATA);
    chk("rst_err", o_free_err, 0);
    chk("rst_wad", wad_dval, 0);
    chk("rst_filled", filled_dval, 0);
    chk("rst_whiaddr", o_whiaddr, 0);
    chk("rst_filled_id", o_filled_id, 0);
    din_rdy = 1; #1 chk("din_ack_idle", din_ack, 0); din_rdy = 0;

    // basic 4-line fill
    alloc(1, 4); fill(1, 4);
    chk("credit_basic", o_credit, NDATA - 4);
    free_line(1);

    // full-ring alloc stalls the next request until retire
    alloc(2, NDATA); fill(2, NDATA);
    chk("credit_zero", o_credit, 0);
    alloc_rdy = 1; i_alloc_id = 3; i_alloc_len = 1;
    for (int k = 0; k < 3; k++) begin #1 chk("stall_ack", alloc_ack, 0); tick(); end
    free_dval = 1; i_free_id = 2; #1 chk("no_bypass_ack", alloc_ack, 0);
    tick(); free_dval = 0;
    void'(qid.pop_front()); void'(qlen.pop_front()); m_credit += NDATA;
    chk("credit_refund", o_credit, NDATA);
    alloc(3, 1); chk("credit_n1", o_credit, NDATA - 1);
    fill(3, 1); free_line(3);

    // ring wrap
    len = (NDATA - 2 - m_wptr + NDATA) % NDATA;
    if (len != 0) begin alloc(4, len); fill(4, len); free_line(4); end
    chk("wptr_pre_wrap", m_wptr, NDATA - 2);
    alloc(5, 4); fill(5, 4); free_line(5);

    // simultaneous free + alloc: credit 2 + 3 - 2
    alloc(1, 3); fill(1, 3);
    alloc(2, NDATA - 5); fill(2, NDATA - 5);
    chk("credit_two", o_credit, 2);
    alloc_rdy = 1; i_alloc_id = 3; i_alloc_len = 2; free_dval = 1; i_free_id = 1;
    #1 chk("sim_ack", alloc_ack, 1);
    tick(); alloc_rdy = 0; free_dval = 0;
    void'(qid.pop_front()); void'(qlen.pop_front());
    qid.push_back(3); qlen.push_back(2); m_credit = 3;
    chk("credit_sim", o_credit, 3);
    fill(3, 2); free_line(2); free_line(3);

    // randomized traffic
    for (int it = 0; it < 10; it++) begin
      id  = $urandom_range(0, (1 << ICFG_BW) - 1);
      len = $urandom_range(1, NDATA / 2);
      while (m_credit < len || qid.size() == N_ICFG) free_line(qid[0]);
      alloc(id, len); fill(id, len);
    end
    while (qid.size() != 0) free_line(qid[0]);
    chk("credit_drained", o_credit, NDATA);

    // illegal lengths: acked, dropped, flag error
    alloc_rdy = 1; i_alloc_len = 0; #1 chk("len0_ack", alloc_ack, 1);
    tick(); alloc_rdy = 0; m_err = 1;
    chk("len0_err", o_free_err, 1); chk("len0_credit", o_credit, NDATA);
    din_rdy = 1; #1 chk("len0_idle", din_ack, 0); din_rdy = 0;
    alloc_rdy = 1; i_alloc_len = LEN_BW'(NDATA + 4); #1 chk("lenbig_ack", alloc_ack, 1);
    tick(); alloc_rdy = 0;
    chk("lenbig_credit", o_credit, NDATA);
    din_rdy = 1; #1 chk("lenbig_idle", din_ack, 0); din_rdy = 0;

    // id mismatch and empty free
    do_reset();
    chk("err_cleared", o_free_err, 0);
    alloc(2, 3); fill(2, 3);
    free_line(5);
    chk("mismatch_credit", o_credit, NDATA);
    free_line(2);
    tick(); tick(); chk("err_sticky", o_free_err, 1);
    do_reset();
    chk("err_reset", o_free_err, 0);

    // reset mid-fill abandons the transfer
    alloc(1, 4);
    din_rdy = 1;
    for (int k = 0; k < 2; k++) begin
      i_din = WD'($urandom); tick();
      chk("pre_rst_wad", wad_dval, 1);
      chk("pre_rst_addr", o_whiaddr, k);
    end
    i_rst = 1; tick();
    chk("rst_fill_wad", wad_dval, 0);
    do_reset();
    din_rdy = 1;
    for (int k = 0; k < 3; k++) begin tick(); chk("post_rst_wad", wad_dval, 0); end
    din_rdy = 0;
    chk("post_rst_credit", o_credit, NDATA);
    alloc(6, 2); fill(6, 2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
